// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its BCD digit slice.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_INC  = 4'h0,
    OP_DEC  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_ROR  = 4'h4,
    OP_ASL  = 4'h5,
    OP_ROL  = 4'h6,
    OP_OR   = 4'h7,
    OP_AND  = 4'h8,
    OP_BIT  = 4'h9,
    OP_EOR  = 4'hA,
    OP_ONES = 4'hB,
    OP_LSR  = 4'hC
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    DIGIT = 2'd2,
    DONE  = 2'd3
  } alu_state_t;

  localparam logic [3:0] BCD_CORRECT = 4'd6;

endpackage

// File: rtl/alu_seq_bcd_digit.sv
// Single BCD digit add/subtract with decimal correction; sub computes b_d - a_d - !cin.
module bcd_digit
  import alu_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] s;
  logic [4:0] t;

  always_comb begin
    s    = {1'b0, a_d} + {1'b0, b_d} + {4'b0, cin};
    // Range is -16..15, so bit 4 is the sign of the difference.
    t    = {1'b0, b_d} - {1'b0, a_d} - {4'b0, ~cin};
    d    = s[3:0];
    cout = 1'b0;
    if (sub) begin
      if (t[4]) begin
        d    = t[3:0] + 4'd10;
        cout = 1'b0;
      end else begin
        d    = t[3:0];
        cout = 1'b1;
      end
    end else if (s > 5'd9) begin
      d    = s[3:0] + BCD_CORRECT;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/ready/valid handshake; decimal ADD/SUB run one digit per cycle.
//   state | meaning
//   IDLE  | ready, waiting for start
//   EXEC  | single-cycle op, result captured on exit
//   DIGIT | one BCD digit per edge, result captured after the last digit
//   DONE  | valid pulse, outputs just updated
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             bcd,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             c_out
);

  localparam int DIGITS = WIDTH / 4;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  alu_state_t state_q, state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, y_q;
  logic             c_q, bcd_q, carry_q;
  logic [IW-1:0]    idx_q;
  logic             zero_q, neg_q, ovf_q, cout_q;

  logic             dec_mode;
  logic [WIDTH-1:0] a_op, res_y, bcd_y;
  logic [WIDTH:0]   sum, inc, dec;
  logic             res_c, res_v, res_z, res_n, bin_v;
  logic [3:0]       dig_a, dig_b, dig_d;
  logic             dig_c;

  assign dec_mode = bcd & ((op == OP_ADD) || (op == OP_SUB));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = dec_mode ? DIGIT : EXEC;
      EXEC:    state_d = DONE;
      DIGIT:   if (idx_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_op  = (op_q == OP_SUB) ? ~a_q : a_q;
    sum   = {1'b0, a_op} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};
    inc   = {1'b0, a_q} + {{WIDTH{1'b0}}, c_q};
    dec   = {1'b0, a_q} - {{WIDTH{1'b0}}, c_q};
    // Carry into the MSB xor carry out of it.
    bin_v = a_op[WIDTH-1] ^ b_q[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH];
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_INC:  {res_c, res_y} = inc;
      OP_DEC:  {res_c, res_y} = dec;
      OP_ADD,
      OP_SUB:  begin {res_c, res_y} = sum; res_v = bin_v; end
      OP_ROR:  begin res_y = {c_q, a_q[WIDTH-1:1]}; res_c = a_q[0]; end
      OP_ASL:  begin res_y = {a_q[WIDTH-2:0], 1'b0}; res_c = a_q[WIDTH-1]; end
      OP_ROL:  begin res_y = {a_q[WIDTH-2:0], c_q}; res_c = a_q[WIDTH-1]; end
      OP_OR:   res_y = a_q | b_q;
      OP_AND:  res_y = a_q & b_q;
      OP_BIT:  begin res_y = a_q & b_q; res_v = a_q[WIDTH-2]; end
      OP_EOR:  res_y = a_q ^ b_q;
      OP_ONES: begin res_y = '1; res_c = 1'b1; end
      OP_LSR:  begin res_y = {1'b0, a_q[WIDTH-1:1]}; res_c = a_q[0]; end
      default: ;
    endcase
    // Unused codes report all flags clear, including zero.
    res_z = (op_q <= OP_LSR) && (res_y == '0);
    res_n = res_y[WIDTH-1] | ((op_q == OP_BIT) & a_q[WIDTH-1]);
  end

  always_comb begin
    dig_a = a_q[4*int'(idx_q) +: 4];
    dig_b = b_q[4*int'(idx_q) +: 4];
    bcd_y = acc_q;
    bcd_y[4*int'(idx_q) +: 4] = dig_d;
  end

  bcd_digit u_digit (
    .a_d  (dig_a),
    .b_d  (dig_b),
    .cin  (carry_q),
    .sub  (op_q == OP_SUB),
    .d    (dig_d),
    .cout (dig_c)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      bcd_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q    <= op;
          a_q     <= a;
          b_q     <= b;
          c_q     <= c_in;
          bcd_q   <= bcd;
          carry_q <= c_in;
          idx_q   <= '0;
          acc_q   <= '0;
        end
        EXEC: begin
          y_q    <= res_y;
          zero_q <= res_z;
          neg_q  <= res_n;
          ovf_q  <= res_v;
          cout_q <= res_c;
        end
        DIGIT: begin
          acc_q   <= bcd_y;
          carry_q <= dig_c;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            y_q    <= bcd_y;
            zero_q <= (bcd_y == '0);
            neg_q  <= bcd_y[WIDTH-1];
            ovf_q  <= bin_v;
            cout_q <= dig_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state_q == IDLE);
  assign valid    = (state_q == DONE);
  assign y        = y_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign c_out    = cout_q;

  // bcd_q is kept with the latched operation for visibility; the FSM path already encodes it.
  logic unused_bcd;
  assign unused_bcd = bcd_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb8, resetb16, start8, start16, c_in, bcd;
  logic [3:0]  op;
  logic [15:0] a, b;

  logic        ready8, valid8, zero8, negative8, overflow8, c_out8;
  logic [7:0]  y8;
  logic        ready16, valid16, zero16, negative16, overflow16, c_out16;
  logic [15:0] y16;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .resetb(resetb8), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .c_in(c_in), .bcd(bcd), .ready(ready8), .valid(valid8), .y(y8), .zero(zero8),
    .negative(negative8), .overflow(overflow8), .c_out(c_out8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .resetb(resetb16), .start(start16), .op(op), .a(a), .b(b),
    .c_in(c_in), .bcd(bcd), .ready(ready16), .valid(valid16), .y(y16), .zero(zero16),
    .negative(negative16), .overflow(overflow16), .c_out(c_out16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op, follows it until ready returns, then checks latency, busy time,
  // pulse count and the captured result. With hold set, start stays high and the
  // operands are scrambled while the unit is busy.
  task automatic run_op(input string tag, input bit w16, input logic [3:0] op_i,
                        input logic [15:0] a_i, input logic [15:0] b_i,
                        input logic cin_i, input logic bcd_i, input bit hold,
                        input int exp_lat, input logic [15:0] exp_y,
                        input logic ec, input logic ev, input logic en, input logic ez);
    int edges, busy, vcount, lat;
    logic [15:0] cy;
    logic [3:0]  cf;
    logic rdy, vld;
    edges = 1; busy = 0; vcount = 0; lat = 0; cy = '0; cf = '0;
    @(negedge clk);
    op = op_i; a = a_i; b = b_i; c_in = cin_i; bcd = bcd_i;
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      op = OP_SUB; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
    end else begin
      start8 = 1'b0; start16 = 1'b0;
    end
    for (int k = 0; k < 30; k++) begin
      rdy = w16 ? ready16 : ready8;
      vld = w16 ? valid16 : valid8;
      if (rdy) break;
      busy++;
      if (vld) begin
        vcount++;
        lat = edges;
        cy = w16 ? y16 : {8'h00, y8};
        cf = w16 ? {c_out16, overflow16, negative16, zero16}
                 : {c_out8, overflow8, negative8, zero8};
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start8 = 1'b0; start16 = 1'b0;
    chk({tag, "_lat"},    lat,    exp_lat);
    chk({tag, "_busy"},   busy,   exp_lat);
    chk({tag, "_pulses"}, vcount, 1);
    chk({tag, "_y"},      cy,     exp_y);
    chk({tag, "_c"},      cf[3],  ec);
    chk({tag, "_v"},      cf[2],  ev);
    chk({tag, "_n"},      cf[1],  en);
    chk({tag, "_z"},      cf[0],  ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetb8 = 1'b0; resetb16 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    op = 4'h0; a = '0; b = '0; c_in = 1'b0; bcd = 1'b0;
    #1;
    chk("rst8_ready",  ready8, 1);
    chk("rst8_valid",  valid8, 0);
    chk("rst8_y",      y8, 0);
    chk("rst8_flags",  {zero8, negative8, overflow8, c_out8}, 0);
    chk("rst16_ready", ready16, 1);
    chk("rst16_y",     y16, 0);
    @(negedge clk);
    @(negedge clk);
    resetb8 = 1'b1; resetb16 = 1'b1;

    //      tag       w16 op       a         b         cin  bcd  hold lat y         c  v  n  z
    run_op("add",     0, OP_ADD,  16'h0050, 16'h0050, 0,   0,   0,   2, 16'h00A0, 0, 1, 1, 0);
    run_op("badd",    0, OP_ADD,  16'h0058, 16'h0046, 1,   1,   0,   3, 16'h0005, 1, 1, 0, 0);
    run_op("bsub",    0, OP_SUB,  16'h0001, 16'h0000, 1,   1,   0,   3, 16'h0099, 0, 0, 1, 0);
    run_op("sub",     0, OP_SUB,  16'h0001, 16'h0000, 1,   0,   0,   2, 16'h00FF, 0, 0, 1, 0);
    run_op("bit",     0, OP_BIT,  16'h00C0, 16'h000F, 0,   0,   0,   2, 16'h0000, 0, 1, 1, 1);
    run_op("ror",     0, OP_ROR,  16'h0001, 16'h0000, 1,   0,   0,   2, 16'h0080, 1, 0, 1, 0);
    run_op("inc",     0, OP_INC,  16'h00FF, 16'h0000, 1,   0,   0,   2, 16'h0000, 1, 0, 0, 1);
    run_op("dec",     0, OP_DEC,  16'h0000, 16'h0000, 1,   0,   0,   2, 16'h00FF, 1, 0, 1, 0);
    run_op("rol",     0, OP_ROL,  16'h0081, 16'h0000, 1,   0,   0,   2, 16'h0003, 1, 0, 0, 0);
    run_op("lsr",     0, OP_LSR,  16'h0081, 16'h0000, 0,   0,   0,   2, 16'h0040, 1, 0, 0, 0);
    run_op("ones",    0, OP_ONES, 16'h0000, 16'h0000, 0,   0,   0,   2, 16'h00FF, 1, 0, 1, 0);
    run_op("eor",     0, OP_EOR,  16'h00A5, 16'h00FF, 0,   0,   0,   2, 16'h005A, 0, 0, 0, 0);
    run_op("op_e",    0, 4'hE,    16'h00A5, 16'h00FF, 1,   0,   0,   2, 16'h0000, 0, 0, 0, 0);
    run_op("or_bcd",  0, OP_OR,   16'h000F, 16'h00F0, 0,   1,   0,   2, 16'h00FF, 0, 0, 1, 0);
    run_op("hold",    0, OP_ADD,  16'h0058, 16'h0046, 1,   1,   1,   3, 16'h0005, 1, 1, 0, 0);
    run_op("add16",   1, OP_ADD,  16'h1234, 16'h1111, 0,   0,   0,   2, 16'h2345, 0, 0, 0, 0);

    // Reset the 16-bit unit while it is on digit 2 of a decimal add.
    @(negedge clk);
    op = OP_ADD; a = 16'h1234; b = 16'h5678; c_in = 1'b0; bcd = 1'b1; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_busy", ready16, 0);
    resetb16 = 1'b0;
    #1;
    chk("mid_rst_y",     y16, 0);
    chk("mid_rst_flags", {zero16, negative16, overflow16, c_out16}, 0);
    chk("mid_rst_ready", ready16, 1);
    chk("mid_rst_valid", valid16, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_hold_valid", valid16, 0);
    end
    resetb16 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_rel_ready", ready16, 1);
      chk("post_rel_valid", valid16, 0);
    end

    run_op("badd16",  1, OP_ADD,  16'h1234, 16'h5678, 0,   1,   0,   5, 16'h6912, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's combinational ALU.
- Width is generic and must be a multiple of 4.
- Adds real decimal (BCD) add/subtract, processed one digit per cycle by a small FSM.
- Uses a start/ready/valid handshake, so the datapath controller can issue one operation and wait for the flag-bearing result.
- Sits between the register file/operand latches and the status-register update logic.

Parameters:
- WIDTH, 8, datapath width in bits; must be a multiple of 4 and at least 8.
- DIGITS, WIDTH/4, number of BCD digits (derived; not to be overridden).

Ports:
- clk  input  1  single system clock, rising-edge.
- resetb  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- op  input  4  operation code, alu_op_t.
- a  input  WIDTH  operand A; inverted operand for SUB.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in.
- bcd  input  1  decimal mode; affects ADD/SUB only.
- ready  output  1  FSM idle, can accept start.
- valid  output  1  one-cycle pulse, result outputs updated.
- y  output  WIDTH  result.
- zero, negative, overflow, c_out  output  1 each  flags.

Behaviour:
- Reset (async, resetb=0): state IDLE; y=0; all flags 0; valid=0; ready=1; in-flight operation discarded. It is not resumed after reset release.
- Accept: start & ready at edge k latches op, a, b, c_in, bcd. While busy, start is ignored and inputs may change freely.
- States and transitions:
  - IDLE: start → EXEC if not (bcd & op∈{ADD,SUB}); otherwise → DIGIT with index i=0 and carry = c_in.
  - EXEC: computes the full result; → DONE.
  - DIGIT: one digit per edge; i increments; after i=DIGITS-1 → DONE.
  - DONE: valid=1 for exactly one cycle; → IDLE. ready=1 only in IDLE.
- Latency (edges from accept to valid):
  - 2 for single-cycle ops.
  - DIGITS+1 for BCD ADD/SUB; for WIDTH=8, 3 edges.
- y and flags hold their value until the next valid. They do not change during DIGIT.
- Op codes:
  - 0 INC: a+c_in.
  - 1 DEC: a−c_in; c_out=borrow.
  - 2 ADD: a+b+c_in.
  - 3 SUB: ~a+b+c_in (b−a−!c_in).
  - 4 ROR: {c_in,a[W-1:1]}; c_out=a[0].
  - 5 ASL: c_out=a[W-1].
  - 6 ROL: shifts c_in in.
  - 7 OR.
  - 8 AND.
  - 9 BIT: y=a&b; c_out=0.
  - A EOR.
  - B ONES: y=all 1s; c_out=1.
  - C LSR: y=a>>1; c_out=a[0].
  - D–F: y=0, flags 0.
  - INC and DEC are mod 2^WIDTH; c_out is the carry/borrow out.
- Flags:
  - zero = (y==0).
  - negative = y[W-1] | (BIT & a[W-1]).
  - Binary ADD/SUB: overflow = carry into MSB XOR carry out of MSB.
  - BIT: overflow = a[W-2].
  - All other ops: overflow = 0.
- BCD add, per digit: s = a_d + b_d + carry (5 bits). If s>9: digit=(s+6)[3:0], carry=1; else digit=s[3:0], carry=0.
- BCD sub, per digit: t = b_d − a_d − !carry. If t<0: digit=(t+10)[3:0], carry=0 (borrow); else digit=t, carry=1.
- c_out = final decimal carry.
- Invalid digits (>9): apply the same formulas and truncate to 4 bits. No error flag.
- BCD flags: zero and negative come from the decimal y. Overflow is the binary-sum overflow of the latched operands, computed in EXEC-equivalent logic.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[3:0] alu_op_t (INC..LSR as above);
  - typedef enum alu_state_t {IDLE, EXEC, DIGIT, DONE};
  - constant BCD_CORRECT=6.
- Submodule bcd_digit: combinational single-digit add/sub with correction. Inputs a_d, b_d, cin, sub; outputs d, cout. Instantiated once and indexed by the digit counter.

Test Plan:
- Binary ADD, WIDTH=8: a=0x50, b=0x50, c_in=0 → valid 2 edges after accept; y=0xA0, c_out=0, overflow=1, negative=1, zero=0.
- BCD ADD: a=0x58, b=0x46, c_in=1, bcd=1 → valid 3 edges after accept; y=0x05, c_out=1, zero=0; ready low for exactly 3 cycles.
- BCD SUB: a=0x01, b=0x00, c_in=1 → y=0x99, c_out=0. Same op with bcd=0 → y=0xFF, c_out=0, 2-edge latency.
- BIT: a=0xC0, b=0x0F → y=0x00, zero=1, negative=1, overflow=1, c_out=0. ROR: a=0x01, c_in=1 → y=0x80, c_out=1.
- Handshake: start held high and operands changed during a BCD op → result uses the first operands only; exactly one valid pulse per accepted start.
- Reset mid-DIGIT, WIDTH=16 BCD ADD: resetb low at digit 2 → y=0, flags 0, ready=1, no valid. A new op after release completes normally with 5-edge latency.
